// File: rtl/mips_regfile_pkg.sv
// Shared definitions for the MIPS register file and the datapath around it.
//   DATA_W / ADDR_W : default word and register-address widths
//   REG_ZERO        : hardwired-zero register index
//   REG_SP / REG_RA : named register indices used by the datapath
package mips_regfile_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   // True when a write to addr would actually change storage.
   function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
      return addr != REG_ZERO;
   endfunction

endpackage

// File: rtl/mips_regfile_reg32_en.sv
// reg32_en: one W-bit register with synchronous active-high reset and load enable.
//   clk   : rising-edge clock
//   reset : synchronous clear, has priority over en
//   en    : load d on the next rising edge
//   d / q : data in / registered data out
module reg32_en #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: 2**ADDR_W x DATA_W register file, two combinational read
// ports and one synchronous write port. Register 0 has no storage and reads 0.
//   clk                  : rising-edge clock
//   reset                : synchronous active-high clear of registers 1..N-1
//   read_reg1/read_reg2  : read addresses (rs / rt)
//   read_data1/read_data2: read data (ALU operands A / B)
//   write_reg/write_data : write address and data
//   reg_write            : write enable
// BYPASS=1 forwards write_data to a read port addressing the register being
// written in the same cycle; BYPASS=0 shows the old contents until the edge.
module mips_regfile
   import mips_regfile_pkg::*;
#(
   parameter int DATA_W_P = DATA_W,
   parameter int ADDR_W_P = ADDR_W,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W_P-1:0] read_reg1,
   input  logic [ADDR_W_P-1:0] read_reg2,
   input  logic [ADDR_W_P-1:0] write_reg,
   input  logic [DATA_W_P-1:0] write_data,
   input  logic                reg_write,
   output logic [DATA_W_P-1:0] read_data1,
   output logic [DATA_W_P-1:0] read_data2
);

   localparam int NREG = 2 ** ADDR_W_P;

   logic [DATA_W_P-1:0] regs [NREG];
   logic [NREG-1:1]     wr_dec;
   logic [DATA_W_P-1:0] rd1_raw;
   logic [DATA_W_P-1:0] rd2_raw;
   logic                wr_live;

   // Write decoder; bit 0 does not exist so writes to $0 fall away naturally.
   always_comb begin
      wr_dec = '0;
      for (int i = 1; i < NREG; i++)
         wr_dec[i] = reg_write && (write_reg == ADDR_W_P'(i));
   end

   assign regs[0] = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_reg
      reg32_en #(.W(DATA_W_P)) u_reg (
         .clk   (clk),
         .reset (reset),
         .en    (wr_dec[g]),
         .d     (write_data),
         .q     (regs[g])
      );
   end

   assign rd1_raw = regs[read_reg1];
   assign rd2_raw = regs[read_reg2];

   // A write that will land this edge; reset kills it, and $0 is never a target.
   assign wr_live = reg_write && !reset && (write_reg != '0);

   if (BYPASS != 0) begin : g_bypass
      assign read_data1 = (wr_live && (read_reg1 == write_reg)) ? write_data : rd1_raw;
      assign read_data2 = (wr_live && (read_reg2 == write_reg)) ? write_data : rd2_raw;
   end else begin : g_no_bypass
      logic unused_wr_live;
      assign unused_wr_live = wr_live;
      assign read_data1 = rd1_raw;
      assign read_data2 = rd2_raw;
   end

endmodule

// File: tb/tb_mips_regfile.sv
module tb_mips_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  read_reg1, read_reg2, write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] model [32];

   always #5 clk = ~clk;

   mips_regfile #(.BYPASS(1)) u_dut_byp (
      .clk        (clk),
      .reset      (reset),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (rd1_b),
      .read_data2 (rd2_b)
   );

   mips_regfile #(.BYPASS(0)) u_dut_nobyp (
      .clk        (clk),
      .reset      (reset),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (rd1_n),
      .read_data2 (rd2_n)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] ra, input logic byp);
      if (ra == 5'd0)
         return 32'h0;
      if (byp && reg_write && !reset && write_reg != 5'd0 && ra == write_reg)
         return write_data;
      return model[ra];
   endfunction

   // One clock cycle: drive inputs, optionally score the pre-edge reads of
   // both builds, then take the edge and update the reference model.
   task automatic do_cycle(input logic rst, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [4:0] r1,
                           input logic [4:0] r2, input logic chk, input string tag);
      exp_t e;
      @(negedge clk);
      reset = rst; reg_write = we; write_reg = wa; write_data = wd;
      read_reg1 = r1; read_reg2 = r2;
      #1;
      if (chk) begin
         e.tag = {tag, "_b1"}; e.exp = exp_read(r1, 1'b1); sb.push_back(e);
         e.tag = {tag, "_b2"}; e.exp = exp_read(r2, 1'b1); sb.push_back(e);
         e.tag = {tag, "_n1"}; e.exp = exp_read(r1, 1'b0); sb.push_back(e);
         e.tag = {tag, "_n2"}; e.exp = exp_read(r2, 1'b0); sb.push_back(e);
         e = sb.pop_front(); check(e.tag, rd1_b, e.exp);
         e = sb.pop_front(); check(e.tag, rd2_b, e.exp);
         e = sb.pop_front(); check(e.tag, rd1_n, e.exp);
         e = sb.pop_front(); check(e.tag, rd2_n, e.exp);
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && wa != 5'd0) begin
         model[wa] = wd;
      end
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 32; i++)
         do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, tag);
   endtask

   initial begin
      reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = '0; read_reg2 = '0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      // Initial reset: contents unknown before the edge, so not scored.
      do_cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, "rst0");
      // Second reset cycle: reads during held reset must be 0.
      do_cycle(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd7, 1'b1, "rst_hold");
      read_all("rst_all");

      do_cycle(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2, 1'b1, "wr8");
      do_cycle(1'b0, 1'b1, 5'd9, 32'h0F0F0F0F, 5'd8, 5'd1, 1'b1, "wr9");
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 1'b1, "rd89");

      // Write to $0 ignored, same cycle and after.
      do_cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "wr0_same");
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 1'b1, "wr0_next");

      // Bypass vs. no-bypass on reg 10.
      do_cycle(1'b0, 1'b1, 5'd10, 32'h00000001, 5'd10, 5'd9, 1'b1, "set10");
      do_cycle(1'b0, 1'b1, 5'd10, 32'h55AA55AA, 5'd10, 5'd10, 1'b1, "byp10");
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b1, "aft10");
      // Different read addresses must not be forwarded.
      do_cycle(1'b0, 1'b1, 5'd11, 32'h13572468, 5'd10, 5'd12, 1'b1, "nobyp_addr");

      // Fill 1..31 with the index, then reset together with a write to reg 5.
      for (int i = 1; i < 32; i++)
         do_cycle(1'b0, 1'b1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 1'b1, "fill");
      read_all("fill_all");
      do_cycle(1'b1, 1'b1, 5'd5, 32'h00001234, 5'd5, 5'd6, 1'b1, "rst_wr5");
      read_all("clr_all");

      // reg_write=0 must not change reg 31; then the real write.
      for (int i = 1; i < 32; i++)
         do_cycle(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0, 1'b0, "refill");
      do_cycle(1'b0, 1'b0, 5'd31, 32'h00400020, 5'd31, 5'd30, 1'b1, "ra_nowe");
      do_cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd29, 1'b1, "ra_chk0");
      do_cycle(1'b0, 1'b1, 5'd31, 32'h00400020, 5'd31, 5'd1, 1'b1, "ra_we");
      read_all("ra_all");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- It sits at both ends of the ALU operand/result interface:
  - Read ports supply operands A and B to the ALU logic units (and, or, add, ...).
  - The write port accepts the ALU/memory result R at end of cycle.
- Register $0 is hardwired to zero. Optional write-through bypass for same-cycle read-after-write.

Parameters:
- DATA_W, 32, width of each register and data port
- ADDR_W, 5, register address width (2**ADDR_W registers)
- BYPASS, 1, 1 = read port returns write data when read addr == write addr and write is active; 0 = returns old contents

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers on the next rising edge
- read_reg1  input  ADDR_W  address for read port 1 (rs)
- read_reg2  input  ADDR_W  address for read port 2 (rt)
- write_reg  input  ADDR_W  destination address (rd/rt after RegDst mux)
- write_data  input  DATA_W  result word to store
- reg_write  input  1  write enable (RegWrite control)
- read_data1  output  DATA_W  contents of read_reg1 (ALU operand A)
- read_data2  output  DATA_W  contents of read_reg2 (ALU operand B)

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Storage: 31 physical registers, indices 1..31. Index 0 has no storage and always reads 0.
- Reset:
  - On a rising clk edge with reset=1, registers 1..31 load 0.
  - Reset has priority over reg_write in the same cycle; the write is dropped.
  - Reset asserted mid-program clears everything in one edge, with no partial state.
- Write:
  - On a rising edge with reset=0, reg_write=1 and write_reg!=0, reg[write_reg] <= write_data.
  - A write to address 0 is silently ignored.
  - reg_write=0 leaves all registers unchanged.
- Read:
  - Combinational, zero latency: read_dataN = (read_regN==0) ? 0 : reg[read_regN].
  - Both ports are independent; both may address the same register.
- Bypass:
  - BYPASS=1: if reg_write=1, reset=0, write_reg!=0 and read_regN==write_reg, then read_dataN = write_data (combinational forward).
  - BYPASS=0: old contents until the edge.
  - Address 0 is never bypassed.
- Output values:
  - During and after reset both outputs read 0 for any address.
  - Before the first reset, contents are undefined (X in sim). Benches must reset first.
- Width: no arithmetic. Addresses are unsigned and cover exactly 2**ADDR_W entries, so no out-of-range case exists.

Decomposition:
- Shared package/include `mips_defs`:
  - DATA_W=32, ADDR_W=5, REG_ZERO=5'd0
  - Named register indices used by the datapath: REG_SP=29, REG_RA=31.
- Sub-modules:
  - `reg32_en`: one DATA_W-bit register with synchronous reset and load enable; instantiated 31 times.
  - 5-to-32 write decoder gated by reg_write.
- Read muxes: two 32:1 DATA_W-wide muxes, built structurally or as generate loops.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read_data = 32'h00000000.
- Write reg 8 = 32'hDEADBEEF, reg 9 = 32'h0F0F0F0F on consecutive edges; then read_reg1=8, read_reg2=9 -> read_data1=32'hDEADBEEF, read_data2=32'h0F0F0F0F.
- Write reg 0 = 32'hFFFFFFFF with reg_write=1 -> read_reg1=0 still returns 32'h0 in the same and next cycles.
- BYPASS=1:
  - With reg 10 holding 32'h1, drive write_reg=10, write_data=32'h55AA55AA, reg_write=1, read_reg1=read_reg2=10 -> both outputs 32'h55AA55AA before the edge.
  - BYPASS=0 build -> outputs 32'h1 before the edge, 32'h55AA55AA after.
- Fill regs 1..31 with value = index; assert reset together with a write of 32'h1234 to reg 5 -> after the edge all regs read 0, reg 5 included.
- Write reg 31 = 32'h00400020 with reg_write=0 -> reg 31 unchanged; repeat with reg_write=1 -> reg 31 reads 32'h00400020, all other regs unchanged.
